// File: rtl/spi_boot_pkg.sv
// Shared definitions for the SPI boot loader: FSM states,
// SPI peripheral register map and flash command opcodes.
package spi_boot_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_CMD,
        S_ADDR_H,
        S_ADDR_M,
        S_ADDR_L,
        S_XFER,
        S_WAIT,
        S_READ,
        S_EMIT,
        S_DESELECT,
        S_FINISH
    } state_t;

    // SPI peripheral registers
    localparam logic [7:0] REG_CS   = 8'h10;
    localparam logic [7:0] REG_DATA = 8'h11;

    // Flash opcodes
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;

    // Chip-select pattern that releases every device
    localparam logic [7:0] CS_NONE = 8'hFF;

    // Byte shifted out while clocking data in, and as the fast-read dummy
    localparam logic [7:0] FILL_BYTE = 8'hFF;

    // Last cycle index (from the read issue) at which read data is awaited
    localparam logic [1:0] READ_TMO_LAST = 2'd3;

endpackage

// File: rtl/spi_boot_loader_if.sv
// Peripheral bus and received-byte stream of the SPI boot loader.
// master = loader side, slave = SPI peripheral plus byte consumer.
interface spi_boot_loader_if;

    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_rw;
    logic       bus_cs;
    logic [7:0] bus_rdata;
    logic       bus_rdata_en;

    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output bus_addr,
        output bus_data,
        output bus_rw,
        output bus_cs,
        input  bus_rdata,
        input  bus_rdata_en,
        output byte_out,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_data,
        input  bus_rw,
        input  bus_cs,
        output bus_rdata,
        output bus_rdata_en,
        input  byte_out,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/spi_bus_access.sv
// Single-cycle peripheral write/read issue plus the per-byte
// settle timer that is armed by every write.
module spi_bus_access #(
    parameter int BYTE_WAIT = 20
) (
    input  logic       clock_sys,
    input  logic       reset,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_data,
    output logic       wait_done,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data,
    output logic       bus_rw,
    output logic       bus_cs
);

    localparam int TW = (BYTE_WAIT < 2) ? 1 : $clog2(BYTE_WAIT + 1);
    localparam logic [TW-1:0] LOAD = TW'(BYTE_WAIT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Reload on each write, then count down the idle-bus cycles
    always_comb begin
        cnt_d = cnt_q;
        if (wr_req) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Timer register
    always_ff @(posedge clock_sys) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The final waiting cycle is the one where the count reads 1
    assign wait_done = (cnt_q <= TW'(1));

    // Bus idles at cs=1, rw=1, addr/data=0 unless an access is issued
    always_comb begin
        bus_cs   = 1'b1;
        bus_rw   = 1'b1;
        bus_addr = 8'h00;
        bus_data = 8'h00;
        if (wr_req) begin
            bus_cs   = 1'b0;
            bus_rw   = 1'b0;
            bus_addr = req_addr;
            bus_data = req_data;
        end else if (rd_req) begin
            bus_cs   = 1'b0;
            bus_addr = req_addr;
        end
    end

endmodule

// File: rtl/spi_boot_loader.sv
// Streams a block of SPI flash through the SPI peripheral into a byte sink.
// Optional SPI_BOOT_FAST_READ_EN: opcode 0x0B plus one dummy byte.
module spi_boot_loader
    import spi_boot_pkg::*;
#(
    parameter logic [7:0] CS_MASK   = 8'hFE,
    parameter int         BYTE_WAIT = 20,
    parameter int         LEN_W     = 16
) (
    input  logic             clock_sys,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      flash_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    spi_boot_loader_if.master io
);

`ifdef SPI_BOOT_FAST_READ_EN
    localparam logic [7:0] CMD_OP    = CMD_FAST_READ;
    localparam logic       USE_DUMMY = 1'b1;
`else
    localparam logic [7:0] CMD_OP    = CMD_READ;
    localparam logic       USE_DUMMY = 1'b0;
`endif

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       byte_q, byte_d;
    logic [1:0]       tmo_q, tmo_d;
    logic             dummy_q, dummy_d;

    logic       wr_req;
    logic       rd_req;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       wait_done;

    spi_bus_access #(
        .BYTE_WAIT(BYTE_WAIT)
    ) u_access (
        .clock_sys(clock_sys),
        .reset    (reset),
        .wr_req   (wr_req),
        .rd_req   (rd_req),
        .req_addr (req_addr),
        .req_data (req_data),
        .wait_done(wait_done),
        .bus_addr (io.bus_addr),
        .bus_data (io.bus_data),
        .bus_rw   (io.bus_rw),
        .bus_cs   (io.bus_cs)
    );

    // Sequencer: one bus access per issuing state, shared WAIT returns via ret_q
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q;
        dummy_d  = dummy_q;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        req_addr = 8'h00;
        req_data = 8'h00;
        done     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        addr_d  = flash_addr;
                        rem_d   = length;
                        state_d = S_SELECT;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_SELECT: begin
                wr_req   = 1'b1;
                req_addr = REG_CS;
                req_data = CS_MASK;
                state_d  = S_CMD;
            end
            S_CMD: begin
                wr_req   = 1'b1;
                req_addr = REG_DATA;
                req_data = CMD_OP;
                ret_d    = S_ADDR_H;
                state_d  = S_WAIT;
            end
            S_ADDR_H: begin
                wr_req   = 1'b1;
                req_addr = REG_DATA;
                req_data = addr_q[23:16];
                ret_d    = S_ADDR_M;
                state_d  = S_WAIT;
            end
            S_ADDR_M: begin
                wr_req   = 1'b1;
                req_addr = REG_DATA;
                req_data = addr_q[15:8];
                ret_d    = S_ADDR_L;
                state_d  = S_WAIT;
            end
            S_ADDR_L: begin
                wr_req   = 1'b1;
                req_addr = REG_DATA;
                req_data = addr_q[7:0];
                dummy_d  = USE_DUMMY;
                ret_d    = S_XFER;
                state_d  = S_WAIT;
            end
            S_XFER: begin
                // A pending dummy byte loops back for one more fill write
                wr_req   = 1'b1;
                req_addr = REG_DATA;
                req_data = FILL_BYTE;
                dummy_d  = 1'b0;
                ret_d    = dummy_q ? S_XFER : S_READ;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = 2'd0;
                if (wait_done) begin
                    state_d = ret_q;
                end
            end
            S_READ: begin
                // Read issued on the first cycle; give up with 0x00 if no data
                rd_req   = (tmo_q == 2'd0);
                req_addr = REG_DATA;
                if (io.bus_rdata_en) begin
                    byte_d  = io.bus_rdata;
                    state_d = S_EMIT;
                end else if (tmo_q == READ_TMO_LAST) begin
                    byte_d  = 8'h00;
                    state_d = S_EMIT;
                end else begin
                    tmo_d = tmo_q + 2'd1;
                end
            end
            S_EMIT: begin
                if (io.byte_ready) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_W'(1)) ? S_DESELECT : S_XFER;
                end
            end
            S_DESELECT: begin
                wr_req   = 1'b1;
                req_addr = REG_CS;
                req_data = CS_NONE;
                state_d  = S_FINISH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset aborts any job straight to IDLE
    always_ff @(posedge clock_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            ret_q   <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            byte_q  <= 8'h00;
            tmo_q   <= 2'd0;
            dummy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            tmo_q   <= tmo_d;
            dummy_q <= dummy_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign io.byte_valid = (state_q == S_EMIT);
    assign io.byte_out   = byte_q;

endmodule

// File: doc/spi_boot_loader.md
SPI_BOOT_LOADER -- requirements
Module: spi_boot_loader

Interface
REQ-001 SHALL have parameter CS_MASK, default 8'hFE, chip-select pattern written to SPI register 0x10 (bit 0 low = boot flash).
REQ-002 SHALL have parameter BYTE_WAIT, default 20, clock_sys cycles allowed for one SPI byte to complete after its write.
REQ-003 SHALL have parameter LEN_W, default 16, width of the length input.
REQ-004 SHALL have the port list below, clock and reset first.
- clock_sys  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- flash_addr  in  24  first flash byte address; latched on start.
- length  in  LEN_W  byte count; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.
- bus_addr  out  8  SPI peripheral register address.
- bus_data  out  8  write data to SPI peripheral.
- bus_rw  out  1  1 = read, 0 = write.
- bus_cs  out  1  active-low peripheral select; low exactly one cycle per access.
- bus_rdata  in  8  SPI peripheral read data.
- bus_rdata_en  in  1  bus_rdata valid qualifier.
- byte_out  out  8  received flash byte.
- byte_valid  out  1  byte_out valid; held until accepted.
- byte_ready  in  1  consumer accepts when byte_valid && byte_ready.

Function
REQ-005 SHALL implement states IDLE, SELECT, CMD, ADDR_H, ADDR_M, ADDR_L, XFER, WAIT, READ, EMIT, DESELECT, FINISH.
REQ-006 SHALL, on start in IDLE with length != 0, latch flash_addr/length and enter SELECT; start outside IDLE SHALL be ignored.
REQ-007 SHALL, on start with length == 0, pulse done one cycle later with no bus access.
REQ-008 SHALL, in SELECT, issue one write cycle: bus_addr 0x10, bus_data CS_MASK.
REQ-009 SHALL issue byte writes to bus_addr 0x11 in order: command 0x03, addr[23:16], addr[15:8], addr[7:0]; each write followed by exactly BYTE_WAIT idle-bus cycles.
REQ-010 SHALL, per data byte: write 0xFF to 0x11 (XFER), wait BYTE_WAIT cycles, issue one read cycle at 0x11 (READ), capture bus_rdata on the cycle bus_rdata_en is high.
REQ-011 SHALL, if bus_rdata_en is not seen within 4 cycles of the read cycle, capture 8'h00 and continue (no hang).
REQ-012 SHALL present captured byte in EMIT with byte_valid high; byte_out stable until handshake; next XFER starts the cycle after handshake.
REQ-013 SHALL decrement a LEN_W-bit remaining counter per accepted byte; counter reaching 0 enters DESELECT.
REQ-014 SHALL, in DESELECT, write 8'hFF to 0x10, then FINISH pulses done and returns to IDLE.
REQ-015 SHALL drive bus_cs high, bus_rw high, bus_addr/bus_data 0x00 whenever no access is issued.
REQ-016 SHALL treat length = 2^LEN_W-1 without counter wrap; flash address wrap is flash-defined, not tracked here.

Reset
REQ-017 SHALL, on reset, enter IDLE: busy 0, done 0, byte_valid 0, byte_out 0x00, bus_cs 1, bus_rw 1, counters 0.
REQ-018 SHALL, on reset mid-job, abort without DESELECT; the SPI peripheral is reset by the same system reset.

Configuration
REQ-019 SHALL, with SPI_BOOT_FAST_READ_EN defined, send command 0x0B followed by one dummy 0xFF write (own BYTE_WAIT) after ADDR_L; without it, command 0x03 and no dummy byte.

Structure
REQ-020 SHALL place state enum, register addresses 0x10/0x11, command opcodes in shared package spi_boot_pkg.
REQ-021 SHALL use sub-module spi_bus_access (one-cycle write/read issue plus BYTE_WAIT timer).

Verification
REQ-022 start, flash_addr 24'h012345, length 2 -> writes 0x10:FE, 0x11:03,01,23,45,FF,FF, 0x10:FF; two byte_valid, done once.
REQ-023 start with length 0 -> done next cycle, bus_cs never low.
REQ-024 byte_ready held low 50 cycles in EMIT -> byte_out stable, no bus access, resumes after ready.
REQ-025 reset asserted during ADDR_M -> next cycle IDLE, busy 0, bus_cs 1.
REQ-026 bus_rdata_en suppressed -> byte_out 0x00 emitted within 4 cycles, job completes.
REQ-027 SPI_BOOT_FAST_READ_EN defined, length 1 -> command 0x0B, one extra 0xFF before data byte.
